// File: rtl/imem_fetch_arbiter_if.sv
// Bundle of the two requester ports and the instruction-memory read port.
// master: requesters + memory side; slave: the arbiter.
interface imem_fetch_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_valid;
  logic [31:0]           f_data;
  logic                  f_fault;

  logic                  d_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_gnt;
  logic                  d_valid;
  logic [31:0]           d_data;
  logic                  d_fault;

  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_instruction;

  modport master (
    output f_req, f_addr, d_req, d_addr,
    output imem_instruction,
    input  f_gnt, f_valid, f_data, f_fault,
    input  d_gnt, d_valid, d_data, d_fault,
    input  imem_address
  );

  modport slave (
    input  f_req, f_addr, d_req, d_addr,
    input  imem_instruction,
    output f_gnt, f_valid, f_data, f_fault,
    output d_gnt, d_valid, d_data, d_fault,
    output imem_address
  );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Round-robin share of the imem read port between fetch (f_) and debug (d_).
// Ports: clock, reset (sync, active-low), bus (slave modport: f_/d_ req/gnt,
// registered valid/data/fault responses, imem_address/imem_instruction).
// IMEM_ARB_DBG_PORT_EN: enables the debug requester; otherwise d_ outputs are 0.
module imem_fetch_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] SIZE       = 32'h0800,
  parameter logic [31:0] FAULT_DATA = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  imem_fetch_arbiter_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR =
    ADDR_WIDTH'(SIZE - 32'd4);

  logic                  f_gnt;
  logic                  d_gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  illegal;
  logic [31:0]           rsp_data;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  f_valid_q, f_valid_d;
  logic                  f_fault_q, f_fault_d;
  logic [31:0]           f_data_q, f_data_d;

`ifdef IMEM_ARB_DBG_PORT_EN
  // 1 = debug won the most recent grant
  logic last_grant_q, last_grant_d;

  always_comb begin
    f_gnt = reset && bus.f_req &&
            (!bus.d_req || last_grant_q);
    d_gnt = reset && bus.d_req &&
            (!bus.f_req || !last_grant_q);
    last_grant_d = last_grant_q;
    if (f_gnt)      last_grant_d = 1'b0;
    else if (d_gnt) last_grant_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  logic unused_dbg;
  assign unused_dbg = ^{bus.d_req, bus.d_addr};

  always_comb begin
    f_gnt = reset && bus.f_req;
    d_gnt = 1'b0;
  end
`endif

  // Without a grant the port keeps the last granted address.
  always_comb begin
    sel_addr = addr_q;
    unique case (1'b1)
      f_gnt:   sel_addr = bus.f_addr;
      d_gnt:   sel_addr = bus.d_addr;
      default: ;
    endcase
  end

  assign illegal  = (sel_addr[1:0] != 2'b00) ||
                    (sel_addr > MAX_ADDR);
  assign rsp_data = illegal ? FAULT_DATA
                            : bus.imem_instruction;

  always_comb begin
    addr_d    = sel_addr;
    f_valid_d = f_gnt;
    f_data_d  = f_data_q;
    f_fault_d = f_fault_q;
    if (f_gnt) begin
      f_data_d  = rsp_data;
      f_fault_d = illegal;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q    <= '0;
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
      f_fault_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      f_valid_q <= f_valid_d;
      f_data_q  <= f_data_d;
      f_fault_q <= f_fault_d;
    end
  end

`ifdef IMEM_ARB_DBG_PORT_EN
  logic        d_valid_q, d_valid_d;
  logic        d_fault_q, d_fault_d;
  logic [31:0] d_data_q, d_data_d;

  always_comb begin
    d_valid_d = d_gnt;
    d_data_d  = d_data_q;
    d_fault_d = d_fault_q;
    if (d_gnt) begin
      d_data_d  = rsp_data;
      d_fault_d = illegal;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
      d_fault_q <= 1'b0;
    end else begin
      d_valid_q <= d_valid_d;
      d_data_q  <= d_data_d;
      d_fault_q <= d_fault_d;
    end
  end

  assign bus.d_valid = d_valid_q;
  assign bus.d_data  = d_data_q;
  assign bus.d_fault = d_fault_q;
`else
  assign bus.d_valid = 1'b0;
  assign bus.d_data  = 32'h0;
  assign bus.d_fault = 1'b0;
`endif

  assign bus.f_gnt        = f_gnt;
  assign bus.d_gnt        = d_gnt;
  assign bus.imem_address = sel_addr;
  assign bus.f_valid      = f_valid_q;
  assign bus.f_data       = f_data_q;
  assign bus.f_fault      = f_fault_q;

endmodule
